rtc_alarm: RTL

- Daily alarm stage directly downstream of rtc_clock; consumes its hours/minutes/seconds/milliseconds outputs every cycle.
- Holds a programmed alarm time (HH:MM), detects the match instant and drives a ring output.
- Supports snooze with a limit, auto-timeout of ringing and software stop/disarm.
- Output feeds the buzzer/LED driver.

---
 rtl/rtc_alarm.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rtc_alarm.sv
// Daily HH:MM alarm with snooze limit, ring auto-timeout and stop/disarm.
// Optional RTC_ALARM_PULSE_EN: ring_o pulses 1 s on / 1 s off while ringing.
module rtc_alarm #(
    parameter int RING_S     = 60,
    parameter int SNOOZE_S   = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic [9:0] milliseconds_i,
    input  logic       set_valid_i,
    input  logic [4:0] set_hours_i,
    input  logic [5:0] set_minutes_i,
    input  logic       arm_i,
    input  logic       disarm_i,
    input  logic       stop_i,
    input  logic       snooze_i,
    output logic       ring_o,
    output logic       armed_o,
    output logic [2:0] snooze_cnt_o,
    output logic       set_err_o,
    output logic [4:0] alarm_hours_o,
    output logic [5:0] alarm_minutes_o,
    output logic [1:0] state_o
);

    // Handshake: every control input is a single-cycle strobe with no ready
    // back-pressure; a strobe seen high at a rising edge is acted on at that
    // edge, and all outputs (including state_o) show the result one cycle later.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    localparam int TMAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d, timer_inc;
    logic [2:0]      cnt_q, cnt_d;
    logic [5:0]      seconds_q;
    logic [4:0]      ah_q;
    logic [5:0]      am_q;
    logic            ring_q, ring_d;
    logic            armed_q;
    logic            err_q;
    logic            sec_tick, match, set_act, set_ok, set_bad;
    logic            ring_expire, snooze_expire;

    assign sec_tick  = (seconds_i != seconds_q);
    assign match     = (hours_i == ah_q) && (minutes_i == am_q) &&
                       (seconds_i == 6'd0) && (milliseconds_i == 10'd0);
    // Disarm outranks set, so a set arriving with disarm is dropped entirely.
    assign set_act   = set_valid_i && !disarm_i;
    assign set_ok    = set_act && (set_hours_i <= 5'd23) && (set_minutes_i <= 6'd59);
    assign set_bad   = set_act && !set_ok;

    assign timer_inc     = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);
    assign ring_expire   = sec_tick && (timer_inc >= TW'(RING_S));
    assign snooze_expire = sec_tick && (timer_inc >= TW'(SNOOZE_S));

    always_comb begin
        state_d = state_q;
        timer_d = sec_tick ? timer_inc : timer_q;
        cnt_d   = cnt_q;
        if (disarm_i) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_i) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (!set_ok && match) begin
                        state_d = S_RINGING;
                        timer_d = '0;
                        cnt_d   = 3'd0;
                    end
                end
                S_RINGING: begin
                    if (set_ok || stop_i) begin
                        state_d = S_ARMED;
                        cnt_d   = 3'd0;
                    end else if (snooze_i && (cnt_q < 3'(MAX_SNOOZE))) begin
                        state_d = S_SNOOZE;
                        cnt_d   = cnt_q + 3'd1;
                        timer_d = '0;
                    end else if (ring_expire) begin
                        state_d = S_ARMED;
                        cnt_d   = 3'd0;
                    end
                end
                S_SNOOZE: begin
                    if (set_ok || stop_i) begin
                        state_d = S_ARMED;
                        cnt_d   = 3'd0;
                    end else if (snooze_expire) begin
                        state_d = S_RINGING;
                        timer_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d == S_IDLE || state_d == S_ARMED) timer_d = '0;
    end

`ifdef RTC_ALARM_PULSE_EN
    logic toggle_q, toggle_d;

    // Starts high on every entry to RINGING (including re-ring after snooze).
    always_comb begin
        toggle_d = 1'b0;
        if (state_d == S_RINGING) begin
            if (state_q != S_RINGING) toggle_d = 1'b1;
            else if (sec_tick)        toggle_d = ~toggle_q;
            else                      toggle_d = toggle_q;
        end
        ring_d = (state_d == S_RINGING) && toggle_d;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) toggle_q <= 1'b0;
        else        toggle_q <= toggle_d;
    end
`else
    always_comb begin
        ring_d = (state_d == S_RINGING);
    end
`endif

    always_ff @(posedge clk_i) begin
        seconds_q <= seconds_i;
        if (srst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= 3'd0;
            ah_q    <= 5'd0;
            am_q    <= 6'd0;
            ring_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ring_q  <= ring_d;
            armed_q <= (state_d != S_IDLE);
            err_q   <= set_bad;
            if (set_ok) begin
                ah_q <= set_hours_i;
                am_q <= set_minutes_i;
            end
        end
    end

    assign ring_o          = ring_q;
    assign armed_o         = armed_q;
    assign snooze_cnt_o    = cnt_q;
    assign set_err_o       = err_q;
    assign alarm_hours_o   = ah_q;
    assign alarm_minutes_o = am_q;
    assign state_o         = state_q;

endmodule
